// File: rtl/led_frame_scheduler_pkg.sv
// Shared constants for the LED frame scheduler.
//   LED_W          width of one LED word
//   SHIFT_LEN_DEF  default number of shift cycles the driver spends per frame
//   S_*            FSM state encodings (3 bits)
`timescale 1ns/1ps
package led_frame_scheduler_pkg;

    localparam int LED_W         = 16;
    localparam int SHIFT_LEN_DEF = 16;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int cnt_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Upstream word handshake between the user logic and the frame scheduler.
//   data_in     16  new LED word, bit15 shifted first
//   data_valid  1   data_in offered this cycle
//   data_ready  1   scheduler's one-entry buffer is empty
// master = word source, slave = scheduler.
`timescale 1ns/1ps
interface led_frame_scheduler_if;
    import led_frame_scheduler_pkg::*;

    logic [LED_W-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/led_frame_scheduler_refresh_timer.sv
// Free-running refresh timer.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  one-cycle pulse every PERIOD cycles; held low when PERIOD=0
// Down-counter reloading from PERIOD-1; the tick is the terminal count.
`timescale 1ns/1ps
module led_frame_scheduler_refresh_timer #(
    parameter int PERIOD = 1000000,
    parameter int CNT_W  = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'((PERIOD == 0) ? 0 : PERIOD - 1);
    localparam logic             ENABLE = (PERIOD != 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = ENABLE && (cnt == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: feeds the 16-LED serial shift driver.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   up          if   word handshake (slave side), one-entry buffer
//   HEXS        out  word presented to the driver, updated on IDLE->LOAD
//   load        out  one-cycle load pulse to the driver
//   busy        out  high in every state except IDLE
//   frame_done  out  one-cycle pulse when a frame's gap finishes
//   frame_cnt   out  frames sent including refreshes, wraps at 255
//
// state   | meaning
// S_INIT  | post-reset wait so an in-flight driver frame can finish
// S_IDLE  | waiting for a pending word or a due refresh
// S_LOAD  | load pulse high for this single cycle
// S_SHIFT | driver shifting, SHIFT_LEN cycles
// S_GAP   | idle gap after the frame, GAP_CYCLES cycles
`timescale 1ns/1ps
module led_frame_scheduler
    import led_frame_scheduler_pkg::*;
#(
    parameter int SHIFT_LEN      = SHIFT_LEN_DEF,
    parameter int GAP_CYCLES     = 2,
    parameter int REFRESH_PERIOD = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_frame_scheduler_if.slave up,
    output logic [LED_W-1:0]     HEXS,
    output logic                 load,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt
);

    localparam int PH_MAX = (SHIFT_LEN > GAP_CYCLES) ? SHIFT_LEN : GAP_CYCLES;
    localparam int PH_W   = cnt_bits(PH_MAX);

    // INIT counts SHIFT_LEN..0, i.e. SHIFT_LEN+1 cycles.
    localparam logic [PH_W-1:0] PH_INIT    = PH_W'(SHIFT_LEN);
    localparam logic [PH_W-1:0] SHIFT_LAST = PH_W'((SHIFT_LEN > 0) ? SHIFT_LEN - 1 : 0);
    localparam logic [PH_W-1:0] GAP_LAST   = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic            HAS_GAP    = (GAP_CYCLES > 0);

    logic [2:0]       state, state_nx;
    logic [PH_W-1:0]  phase, phase_nx;
    logic             done_nx;
    logic             start_frame;
    logic             take_word;

    logic             pending;
    logic [LED_W-1:0] pend_data;
    logic             ready_q;
    logic             accept;
    logic             refresh_due;
    logic             tick;

    led_frame_scheduler_refresh_timer #(
        .PERIOD (REFRESH_PERIOD),
        .CNT_W  (CNT_W)
    ) u_refresh_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign up.data_ready = ready_q;
    assign accept        = up.data_valid & ready_q;

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        done_nx     = 1'b0;
        start_frame = 1'b0;
        take_word   = 1'b0;
        case (state)
            S_INIT: begin
                if (phase == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    phase_nx = phase - 1'b1;
                end
            end
            S_IDLE: begin
                // A pending word takes priority and also satisfies a due refresh.
                if (pending) begin
                    state_nx    = S_LOAD;
                    start_frame = 1'b1;
                    take_word   = 1'b1;
                end else if (refresh_due) begin
                    state_nx    = S_LOAD;
                    start_frame = 1'b1;
                end
            end
            S_LOAD: begin
                state_nx = S_SHIFT;
                phase_nx = SHIFT_LAST;
            end
            S_SHIFT: begin
                if (phase == '0) begin
                    if (HAS_GAP) begin
                        state_nx = S_GAP;
                        phase_nx = GAP_LAST;
                    end else begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    phase_nx = phase - 1'b1;
                end
            end
            S_GAP: begin
                if (phase == '0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    phase_nx = phase - 1'b1;
                end
            end
            default: begin
                state_nx = S_INIT;
                phase_nx = PH_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            phase      <= PH_INIT;
            load       <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            HEXS       <= '0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            load       <= start_frame;
            busy       <= (state_nx != S_IDLE);
            frame_done <= done_nx;
            if (start_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (take_word) begin
                HEXS <= pend_data;
            end
        end
    end

    // ready drops on the accepting edge itself so a held data_valid cannot
    // overwrite the buffer; it rises one cycle after pending clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pend_data <= '0;
            ready_q   <= 1'b1;
        end else begin
            if (accept) begin
                pending   <= 1'b1;
                pend_data <= up.data_in;
            end else if (take_word) begin
                pending <= 1'b0;
            end
            ready_q <= accept ? 1'b0 : ~pending;
        end
    end

    // A wrap arriving on the LOAD entry edge keeps the flag set: it belongs
    // to the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_due <= 1'b0;
        end else if (tick) begin
            refresh_due <= 1'b1;
        end else if (start_frame) begin
            refresh_due <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
`timescale 1ns/1ps
module tb_led_frame_scheduler;
    import led_frame_scheduler_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;

    led_frame_scheduler_if if0();
    led_frame_scheduler_if if1();

    logic [15:0] hexs0, hexs1;
    logic        load0, busy0, done0;
    logic        load1, busy1, done1;
    logic [7:0]  fcnt0, fcnt1;

    led_frame_scheduler #(.REFRESH_PERIOD(0), .CNT_W(20)) dut0 (
        .clk(clk), .rst_n(rst_n0), .up(if0.slave), .HEXS(hexs0), .load(load0),
        .busy(busy0), .frame_done(done0), .frame_cnt(fcnt0)
    );

    led_frame_scheduler #(.REFRESH_PERIOD(50), .CNT_W(20)) dut1 (
        .clk(clk), .rst_n(rst_n1), .up(if1.slave), .HEXS(hexs1), .load(load1),
        .busy(busy1), .frame_done(done1), .frame_cnt(fcnt1)
    );

    typedef struct {
        logic [15:0] w;
        logic [7:0]  c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int   checks   = 0;
    int   failures = 0;
    int   loads0   = 0;
    int   loads1   = 0;
    time  last_t0  = 0, prev_t0 = 0;
    time  last_t1  = 0, prev_t1 = 0;
    time  t_rel1   = 0;
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: one expected entry per load pulse.
    always @(negedge clk) begin
        if (load0) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load0_unexpected: got HEXS %h frame_cnt %0d expected no load", hexs0, fcnt0);
            end else begin
                e0 = q0.pop_front();
                check("load0_hexs", 64'(hexs0), 64'(e0.w));
                check("load0_frame_cnt", 64'(fcnt0), 64'(e0.c));
            end
            prev_t0 = last_t0;
            last_t0 = $time;
            loads0++;
        end
    end

    always @(negedge clk) begin
        if (load1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load1_unexpected: got HEXS %h frame_cnt %0d expected no load", hexs1, fcnt1);
            end else begin
                e1 = q1.pop_front();
                check("load1_hexs", 64'(hexs1), 64'(e1.w));
                check("load1_frame_cnt", 64'(fcnt1), 64'(e1.c));
            end
            prev_t1 = last_t1;
            last_t1 = $time;
            loads1++;
        end
    end

    task automatic expect0(input logic [15:0] w);
        exp_cnt0 = exp_cnt0 + 8'd1;
        q0.push_back('{w, exp_cnt0});
    endtask

    task automatic expect1(input logic [15:0] w);
        exp_cnt1 = exp_cnt1 + 8'd1;
        q1.push_back('{w, exp_cnt1});
    endtask

    // Called just after a negedge; the word transfers on the next posedge with ready high.
    task automatic write0(input logic [15:0] w);
        int n;
        if0.data_in    = w;
        if0.data_valid = 1'b1;
        n = 0;
        while (!if0.data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("write0_ready_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1;
        if0.data_valid = 1'b0;
    endtask

    task automatic wait_load0(input string name);
        int n;
        n = 0;
        while (!load0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(load0), 64'd1);
    endtask

    task automatic wait_loads0(input int target, input string name);
        int n;
        n = 0;
        while (loads0 < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(loads0 >= target), 64'd1);
    endtask

    task automatic wait_loads1(input int target, input string name);
        int n;
        n = 0;
        while (loads1 < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(loads1 >= target), 64'd1);
    endtask

    // Called right after releasing reset on a negedge.
    task automatic init_check0(input string name);
        int cnt;
        int ld;
        cnt = 0;
        ld  = 0;
        while (busy0 && cnt < 100) begin
            cnt++;
            if (load0) ld++;
            @(negedge clk);
        end
        check({name, "_busy_len"}, 64'(cnt), 64'd17);
        check({name, "_no_load"}, 64'(ld), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        if0.data_in = '0; if0.data_valid = 1'b0;
        if1.data_in = '0; if1.data_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_hexs", 64'(hexs0), 64'h0);
        check("rst_load", 64'(load0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd1);
        check("rst_frame_done", 64'(done0), 64'd0);
        check("rst_frame_cnt", 64'(fcnt0), 64'd0);
        check("rst_ready", 64'(if0.data_ready), 64'd1);

        // 1: INIT wait with refresh disabled
        rst_n0 = 1'b1;
        init_check0("t1_init");

        // 2: single word frame
        expect0(16'hA5C3);
        write0(16'hA5C3);
        wait_load0("t2_load_seen");
        cnt = 0;
        while (busy0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_busy_len", 64'(cnt), 64'd19);
        check("t2_frame_done", 64'(done0), 64'd1);
        check("t2_frame_cnt", 64'(fcnt0), 64'd1);
        @(negedge clk);
        check("t2_frame_done_pulse", 64'(done0), 64'd0);

        // 3: write during SHIFT, second word held off by ready
        expect0(16'h1111);
        write0(16'h1111);
        wait_load0("t3_first_load");
        repeat (3) @(negedge clk);
        expect0(16'h0001);
        write0(16'h0001);
        @(negedge clk);
        check("t3_ready_low", 64'(if0.data_ready), 64'd0);
        expect0(16'h0002);
        write0(16'h0002);
        wait_loads0(4, "t3_loads_seen");
        check("t3_interval", 64'(last_t0 - prev_t0), 64'd200);

        // 6: reset mid-SHIFT
        @(negedge clk);
        expect0(16'h00F0);
        write0(16'h00F0);
        wait_load0("t6_load_seen");
        repeat (8) @(negedge clk);
        check("t6_busy_shift", 64'(busy0), 64'd1);
        #2 rst_n0 = 1'b0;
        #1;
        check("t6_rst_hexs", 64'(hexs0), 64'h0);
        check("t6_rst_frame_cnt", 64'(fcnt0), 64'd0);
        check("t6_rst_load", 64'(load0), 64'd0);
        check("t6_rst_busy", 64'(busy0), 64'd1);
        repeat (2) @(negedge clk);
        rst_n0   = 1'b1;
        exp_cnt0 = 8'd0;
        init_check0("t6_init");
        expect0(16'h3C3C);
        write0(16'h3C3C);
        wait_loads0(6, "t6_reload_seen");
        check("t6_post_hexs", 64'(hexs0), 64'h3C3C);

        // 4: periodic refresh, HEXS unchanged
        @(negedge clk);
        rst_n1 = 1'b1;
        t_rel1 = $time;
        expect1(16'h0000);
        expect1(16'h0000);
        expect1(16'h0000);
        wait_loads1(1, "t4_first_refresh");
        check("t4_first_time", 64'(last_t1 - t_rel1), 64'd510);
        wait_loads1(3, "t4_third_refresh");
        check("t4_interval", 64'(last_t1 - prev_t1), 64'd500);

        // 5: write lands on the same edge as the refresh tick
        n = 0;
        while ($time < t_rel1 + 1990 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5_idle", 64'(busy1), 64'd0);
        check("t5_ready", 64'(if1.data_ready), 64'd1);
        expect1(16'hBEEF);
        expect1(16'hBEEF);
        if1.data_in    = 16'hBEEF;
        if1.data_valid = 1'b1;
        @(posedge clk);
        #1;
        if1.data_valid = 1'b0;
        wait_loads1(4, "t5_merged_load");
        check("t5_load_time", 64'(last_t1 - t_rel1), 64'd2010);
        wait_loads1(5, "t5_next_refresh");
        check("t5_interval", 64'(last_t1 - prev_t1), 64'd500);

        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
